// File: rtl/alu_op_sequencer_if.sv
// Host/config and ALU-facing bus of the ALU operation sequencer.
// The sequencer attaches through the slave modport; host and ALU sit on the master side.
interface alu_op_sequencer_if #(
  parameter int AW = 3
);
  // program load
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_a;
  logic [7:0]    wr_b;
  logic [5:0]    wr_sel;

  // run control and status
  logic          start;
  logic [AW:0]   num_ops;
  logic          busy;
  logic          done;
  logic [7:0]    sig;

  // ALU datapath
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [5:0]    alu_sel;
  logic [7:0]    alu_f;

  // result buffer read port
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  modport slave (
    input  wr_en, wr_addr, wr_a, wr_b, wr_sel,
    input  start, num_ops,
    output busy, done, sig,
    output alu_a, alu_b, alu_sel,
    input  alu_f,
    input  rd_addr,
    output rd_data
  );

  modport master (
    output wr_en, wr_addr, wr_a, wr_b, wr_sel,
    output start, num_ops,
    input  busy, done, sig,
    input  alu_a, alu_b, alu_sel,
    output alu_f,
    output rd_addr,
    input  rd_data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Replays a stored {A, B, Sel} program into an ALU181, captures each F into a
// result buffer and folds every captured result into a rotate-xor signature.
module alu_op_sequencer #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int SETTLE_CYC = 1
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  localparam int CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYC);
  localparam logic [AW:0]   DEPTH_N     = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0]    prog_a   [DEPTH];
  logic [7:0]    prog_b   [DEPTH];
  logic [5:0]    prog_sel [DEPTH];
  logic [7:0]    result   [DEPTH];

  logic [AW-1:0] idx;
  logic [AW:0]   n_ops;
  logic [CW-1:0] settle_cnt;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [5:0]    alu_sel;
  logic [7:0]    sig;
  logic          busy;
  logic          done;

  logic [AW:0]   start_n;
  logic          last_op;

  assign start_n = (bus.num_ops > DEPTH_N) ? DEPTH_N : bus.num_ops;
  assign last_op = ({1'b0, idx} == (n_ops - (AW + 1)'(1)));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = (start_n == '0) ? S_DONE : S_APPLY;
        end
      end
      S_APPLY: begin
        busy     = 1'b1;
        state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_cnt == CW'(1)) begin
          state_nx = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy     = 1'b1;
        state_nx = last_op ? S_DONE : S_APPLY;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      n_ops      <= '0;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      sig        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        result[i] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            n_ops <= start_n;
            idx   <= '0;
            sig   <= '0;
          end
        end
        S_APPLY: begin
          alu_a      <= prog_a[idx];
          alu_b      <= prog_b[idx];
          alu_sel    <= prog_sel[idx];
          settle_cnt <= SETTLE_INIT;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - CW'(1);
        end
        S_CAPTURE: begin
          result[idx] <= bus.alu_f;
          sig         <= {sig[6:0], sig[7]} ^ bus.alu_f;
          if (!last_op) begin
            idx <= idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && bus.wr_en) begin
      prog_a[bus.wr_addr]   <= bus.wr_a;
      prog_b[bus.wr_addr]   <= bus.wr_b;
      prog_sel[bus.wr_addr] <= bus.wr_sel;
    end
  end

  assign bus.alu_a   = alu_a;
  assign bus.alu_b   = alu_b;
  assign bus.alu_sel = alu_sel;
  assign bus.sig     = sig;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.rd_data = result[bus.rd_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: two sequencers (settle 1 and settle 3) driving an adder stand-in for ALU181.
module tb_alu_op_sequencer;

  logic clk;
  logic rst;
  int   nchk;
  int   nfail;

  alu_op_sequencer_if #(.AW(3)) b1 ();
  alu_op_sequencer_if #(.AW(3)) b3 ();

  assign b1.alu_f = b1.alu_a + b1.alu_b;
  assign b3.alu_f = b3.alu_a + b3.alu_b;

  alu_op_sequencer #(.DEPTH(8), .AW(3), .SETTLE_CYC(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  alu_op_sequencer #(.DEPTH(8), .AW(3), .SETTLE_CYC(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] snap_a   [1:20];
  logic [7:0] snap_b   [1:20];
  logic [5:0] snap_sel [1:20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_both(input logic [2:0] addr, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] sel);
    b1.wr_en = 1'b1; b1.wr_addr = addr; b1.wr_a = a; b1.wr_b = b; b1.wr_sel = sel;
    b3.wr_en = 1'b1; b3.wr_addr = addr; b3.wr_a = a; b3.wr_b = b; b3.wr_sel = sel;
    step();
    b1.wr_en = 1'b0;
    b3.wr_en = 1'b0;
  endtask

  task automatic start1(input logic [3:0] n);
    b1.num_ops = n;
    b1.start   = 1'b1;
    step();
    b1.start   = 1'b0;
  endtask

  // Called just after the start edge; cycle k is the k-th cycle after that edge.
  task automatic watch1(input int first, input int max, output int busy_cnt, output int done_cyc);
    busy_cnt = 0;
    done_cyc = 0;
    for (int k = first; k <= max && done_cyc == 0; k++) begin
      if (b1.busy) busy_cnt++;
      if (b1.done) done_cyc = k;
      step();
    end
  endtask

  task automatic watch3(input int max, output int busy_cnt, output int done_cyc);
    busy_cnt = 0;
    done_cyc = 0;
    for (int k = 1; k <= max && done_cyc == 0; k++) begin
      if (k <= 20) begin
        snap_a[k]   = b3.alu_a;
        snap_b[k]   = b3.alu_b;
        snap_sel[k] = b3.alu_sel;
      end
      if (b3.busy) busy_cnt++;
      if (b3.done) done_cyc = k;
      step();
    end
  endtask

  task automatic chk_res1(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    b1.rd_addr = addr;
    #1;
    chk(tag, b1.rd_data, exp);
  endtask

  initial begin
    int bc;
    int dc;
    int bad;
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    logic [5:0] es [3];

    nchk  = 0;
    nfail = 0;
    rst   = 1'b1;
    b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_a = '0; b1.wr_b = '0; b1.wr_sel = '0;
    b1.start = 1'b0; b1.num_ops = '0; b1.rd_addr = '0;
    b3.wr_en = 1'b0; b3.wr_addr = '0; b3.wr_a = '0; b3.wr_b = '0; b3.wr_sel = '0;
    b3.start = 1'b0; b3.num_ops = '0; b3.rd_addr = '0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk("rst_alu_a", b1.alu_a, 8'h00);
    chk("rst_alu_b", b1.alu_b, 8'h00);
    chk("rst_alu_sel", b1.alu_sel, 6'h00);
    chk("rst_busy", b1.busy, 1'b0);
    chk("rst_done", b1.done, 1'b0);
    chk("rst_sig", b1.sig, 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk_res1("rst_result", 3'(i), 8'h00);
    end

    wr_both(3'd0, 8'h85, 8'hAA, 6'h0F);
    wr_both(3'd1, 8'h01, 8'hFF, 6'h01);
    wr_both(3'd2, 8'h10, 8'h20, 6'h0B);

    // three-op run
    start1(4'd3);
    watch1(1, 40, bc, dc);
    chk("run3_busy_cycles", bc, 9);
    chk("run3_done_cycle", dc, 10);
    chk_res1("run3_res0", 3'd0, 8'h2F);
    chk_res1("run3_res1", 3'd1, 8'h00);
    chk_res1("run3_res2", 3'd2, 8'h30);
    chk("run3_sig", b1.sig, 8'h8C);
    chk("run3_alu_sel", b1.alu_sel, 6'h0B);
    chk("run3_alu_a", b1.alu_a, 8'h10);
    chk("run3_alu_b", b1.alu_b, 8'h20);
    chk("run3_idle_busy", b1.busy, 1'b0);

    // zero-op run
    start1(4'd0);
    watch1(1, 10, bc, dc);
    chk("run0_busy_cycles", bc, 0);
    chk("run0_done_cycle", dc, 1);
    chk("run0_sig", b1.sig, 8'h00);
    chk_res1("run0_res0", 3'd0, 8'h2F);
    chk_res1("run0_res1", 3'd1, 8'h00);
    chk_res1("run0_res2", 3'd2, 8'h30);

    // write and start during a run are ignored
    start1(4'd3);
    b1.wr_en = 1'b1; b1.wr_addr = 3'd0; b1.wr_a = 8'hFF; b1.wr_b = 8'hFF; b1.wr_sel = 6'h3F;
    b1.num_ops = 4'd1;
    b1.start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("ign_busy", b1.busy, 1'b1);
      step();
    end
    b1.wr_en = 1'b0;
    b1.start = 1'b0;
    watch1(5, 40, bc, dc);
    chk("ign_done_cycle", dc, 10);
    chk("ign_busy_rest", bc, 5);
    chk("ign_sig", b1.sig, 8'h8C);
    chk("ign_alu_sel", b1.alu_sel, 6'h0B);
    start1(4'd3);
    watch1(1, 40, bc, dc);
    chk("rerun_done_cycle", dc, 10);
    chk_res1("rerun_res0", 3'd0, 8'h2F);
    chk("rerun_sig", b1.sig, 8'h8C);

    // settle of 3 cycles; operands held from SETTLE through CAPTURE of each op
    b3.num_ops = 4'd3;
    b3.start   = 1'b1;
    step();
    b3.start   = 1'b0;
    watch3(60, bc, dc);
    chk("s3_done_cycle", dc, 16);
    chk("s3_busy_cycles", bc, 15);
    ea[0] = 8'h85; eb[0] = 8'hAA; es[0] = 6'h0F;
    ea[1] = 8'h01; eb[1] = 8'hFF; es[1] = 6'h01;
    ea[2] = 8'h10; eb[2] = 8'h20; es[2] = 6'h0B;
    for (int j = 0; j < 3; j++) begin
      bad = 0;
      for (int c = 2 + 5 * j; c <= 5 + 5 * j; c++) begin
        if (snap_a[c] !== ea[j] || snap_b[c] !== eb[j] || snap_sel[c] !== es[j]) bad++;
      end
      chk("s3_hold_op", bad, 0);
    end
    chk("s3_sig", b3.sig, 8'h8C);
    b3.rd_addr = 3'd2;
    #1;
    chk("s3_res2", b3.rd_data, 8'h30);

    // reset during SETTLE of the second op (cycle 5)
    start1(4'd3);
    for (int k = 1; k <= 4; k++) step();
    chk("mid_busy_before", b1.busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", b1.busy, 1'b0);
    chk("mid_done", b1.done, 1'b0);
    chk("mid_alu_a", b1.alu_a, 8'h00);
    chk("mid_alu_sel", b1.alu_sel, 6'h00);
    chk("mid_sig", b1.sig, 8'h00);
    chk_res1("mid_res0", 3'd0, 8'h00);
    step();
    chk("mid_still_idle", b1.busy, 1'b0);
    start1(4'd3);
    watch1(1, 40, bc, dc);
    chk("post_done_cycle", dc, 10);
    chk("post_sig", b1.sig, 8'h8C);
    chk_res1("post_res0", 3'd0, 8'h2F);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Synthesizable driver and collector for the ALU181 datapath. It is the hardware counterpart of the stimulus side: it replays a stored program of {A, B, Sel} operations into the ALU and captures each F result into a result buffer.
- A running signature over all captured results is kept for on-chip self-check.
- Sits between a host/config interface and an ALU181 instance. The ALU's A/B/Sel are driven from this block; the ALU's F feeds back into it.

Parameters:
- DEPTH, 8, number of program/result entries (power of 2, at least 2).
- AW, 3, address width, log2(DEPTH).
- SETTLE_CYC, 1, cycles operands are held before F is captured (at least 1).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  program write strobe; honoured only in IDLE.
- wr_addr  in  AW  program entry index.
- wr_a  in  8  operand A for the entry.
- wr_b  in  8  operand B for the entry.
- wr_sel  in  6  ALU select for the entry.
- start  in  1  begin a run; honoured only in IDLE.
- num_ops  in  AW+1  operations to run, 0..DEPTH; sampled with start.
- alu_a  out  8  registered operand A to the ALU.
- alu_b  out  8  registered operand B to the ALU.
- alu_sel  out  6  registered select to the ALU.
- alu_f  in  8  ALU result, combinational from alu_a/alu_b/alu_sel.
- rd_addr  in  AW  result buffer index.
- rd_data  out  8  result[rd_addr], asynchronous read.
- busy  out  1  high in APPLY, SETTLE and CAPTURE.
- done  out  1  one-cycle pulse in DONE.
- sig  out  8  result signature, stable from DONE until the next start.

Behaviour:
- Reset: state goes to IDLE. alu_a, alu_b, alu_sel, busy, done, sig, idx and the settle counter all go to 0. The result buffer is cleared to 0; the program memory is not cleared.
- Reset mid-run aborts immediately; the next cycle is IDLE with all outputs at 0.
- IDLE:
  - wr_en writes {wr_a, wr_b, wr_sel} to prog[wr_addr] at the edge.
  - On start: latch num_ops, set idx=0, sig=0.
  - If num_ops==0, go to DONE; otherwise go to APPLY.
  - wr_en together with start: the write completes at the same edge and the run uses the updated entry.
- APPLY (1 cycle): load alu_a/alu_b/alu_sel from prog[idx] at the exit edge, set settle counter to SETTLE_CYC, go to SETTLE.
- SETTLE: operands are held. The counter decrements each cycle; after SETTLE_CYC cycles go to CAPTURE.
- CAPTURE (1 cycle):
  - At the exit edge, result[idx] <= alu_f and sig <= {sig[6:0], sig[7]} ^ alu_f.
  - If idx == num_ops-1, go to DONE; otherwise idx++ and go to APPLY.
- DONE (1 cycle): done=1, then go to IDLE.
- alu_* hold their last values after the run.
- Per-op cost is 2+SETTLE_CYC cycles. done is asserted in cycle 1+num_ops*(2+SETTLE_CYC) after the start edge; this is 1 cycle for num_ops==0.
- num_ops > DEPTH is saturated to DEPTH.
- idx never wraps within a run.
- wr_en and start outside IDLE are ignored; no queuing.
- rd_addr is readable at any time. An entry not written in the current run keeps its old value.
- Widths: all data is 8-bit. Sel is passed through unmodified and its encoding is owned by ALU181.

Test Plan:
- Test bench model: alu_f = alu_a + alu_b mod 256, SETTLE_CYC=1.
- Reset → alu_a=alu_b=0, alu_sel=0, busy=0, done=0, sig=0, every rd_data=00.
- Program {85,AA,0F}, {01,FF,01}, {10,20,0B}, num_ops=3, pulse start:
  - busy is high for 9 cycles.
  - done is high in cycle 10.
  - result[0..2] = 2F, 00, 30.
  - sig = 8C.
  - alu_sel = 0B after the run.
- num_ops=0 with start → done in the cycle after start, busy never high, sig=00, result buffer unchanged.
- During the 3-op run, assert wr_en to entry 0 with {FF,FF,3F} and a second start → both are ignored. prog[0] is unchanged, verified by rerunning and reading result[0]=2F.
- Set SETTLE_CYC=3 and rerun the 3-op program → done in cycle 16; alu_a/b/sel are held stable for 4 cycles per op.
- Assert rst in the SETTLE state of op 1 → next cycle IDLE, busy=0, result[0]=00. A fresh start then completes normally with sig=8C.
